// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the single-bus ALU instruction sequencer:
// opcodes, IR field positions, FSM state and instruction class.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_T6   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CLS_BIN = 2'd0,  // two register operands, result to Ra
        CLS_MD  = 2'd1,  // mul/div, result to LO/HI
        CLS_UN  = 2'd2,  // single operand Rb, result to Ra
        CLS_ILL = 2'd3   // unsupported opcode
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: op_class = CLS_BIN;
            OP_MUL, OP_DIV:                  op_class = CLS_MD;
            OP_NEG, OP_NOT:                  op_class = CLS_UN;
            default:                         op_class = CLS_ILL;
        endcase
    endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Handshake, IR and datapath strobe bundle between the sequencer (slave)
// and whatever drives it / consumes its strobes (master).
interface alu_instr_sequencer_if;
    logic        start;
    logic        mem_ready;
    logic [31:0] ir;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        mem_timeout;
    logic        PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin;
    logic        MDRread, MDRin, MDRout, IRin, Yin, LOin, HIin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  ALU_opcode;

    modport master (
        output start, mem_ready, ir,
        input  busy, done, illegal, mem_timeout,
        input  PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin,
        input  MDRread, MDRin, MDRout, IRin, Yin, LOin, HIin,
        input  Rin, Rout, ALU_opcode
    );

    modport slave (
        input  start, mem_ready, ir,
        output busy, done, illegal, mem_timeout,
        output PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin,
        output MDRread, MDRin, MDRout, IRin, Yin, LOin, HIin,
        output Rin, Rout, ALU_opcode
    );
endinterface

// File: rtl/reg_sel_decoder.sv
// 4-bit register index to 16-bit one-hot enable, gated by en_i.
module reg_sel_decoder (
    input  logic [3:0]  idx_i,
    input  logic        en_i,
    output logic [15:0] onehot_o
);
    // at most one bit set, none when disabled
    always_comb begin
        onehot_o = '0;
        if (en_i) onehot_o[idx_i] = 1'b1;
    end
endmodule

// File: rtl/alu_instr_sequencer.sv
// Hardwired control for the single-bus datapath: fetch (T0-T2) then one
// register-register ALU, mul/div or unary instruction (T3-T6).
module alu_instr_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                 clk,
    input  logic                 clr,
    alu_instr_sequencer_if.slave bus
);
    localparam int WW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_t      state_q;
    op_class_t   cls_q;
    logic [WW-1:0] wait_q;
    logic        done_q, illegal_q, timeout_q;

    op_class_t   dec_cls;
    logic [4:0]  opc;
    logic [3:0]  ra, rb, rc;
    logic        rin_en, rout_en;
    logic [3:0]  rin_idx, rout_idx;
    logic [15:0] rin, rout;
    logic        unused_ir_bits;

    assign opc     = bus.ir[OPC_MSB:OPC_LSB];
    assign ra      = bus.ir[RA_MSB:RA_LSB];
    assign rb      = bus.ir[RB_MSB:RB_LSB];
    assign rc      = bus.ir[RC_MSB:RC_LSB];
    assign dec_cls = op_class(opc);
    assign unused_ir_bits = ^bus.ir[RC_LSB-1:0];

    // sequencing FSM; completion/abort pulses are registered with the transition
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            cls_q     <= CLS_BIN;
            wait_q    <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: if (bus.start) state_q <= S_T0;
                S_T0: begin
                    state_q <= S_T1;
                    wait_q  <= '0;
                end
                S_T1: begin
                    // ready wins even on the last allowed wait cycle
                    if (bus.mem_ready) begin
                        state_q <= S_T2;
                    end else if (wait_q == WW'(MEM_WAIT_MAX - 1)) begin
                        state_q   <= S_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_T2: state_q <= S_T3;
                S_T3: begin
                    if (dec_cls == CLS_ILL) begin
                        state_q   <= S_IDLE;
                        illegal_q <= 1'b1;
                    end else begin
                        cls_q   <= dec_cls;
                        state_q <= S_T4;
                    end
                end
                S_T4: state_q <= S_T5;
                S_T5: begin
                    if (cls_q == CLS_MD) begin
                        state_q <= S_T6;
                    end else begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                S_T6: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Moore strobe decode; T3 routing comes straight from IR, later states from the latched class
    always_comb begin
        bus.PCout   = 1'b0;
        bus.MARin   = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Zin     = 1'b0;
        bus.ZLOout  = 1'b0;
        bus.ZHIout  = 1'b0;
        bus.PCin    = 1'b0;
        bus.MDRread = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.LOin    = 1'b0;
        bus.HIin    = 1'b0;
        bus.ALU_opcode = 5'b0;
        rin_en   = 1'b0;
        rin_idx  = ra;
        rout_en  = 1'b0;
        rout_idx = rb;
        case (state_q)
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            S_T1: begin
                bus.ZLOout  = 1'b1;
                bus.PCin    = 1'b1;
                bus.MDRread = 1'b1;
                bus.MDRin   = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (dec_cls == CLS_BIN) begin
                    rout_en  = 1'b1;
                    rout_idx = rb;
                    bus.Yin  = 1'b1;
                end else if (dec_cls == CLS_MD) begin
                    rout_en  = 1'b1;
                    rout_idx = ra;
                    bus.Yin  = 1'b1;
                end
            end
            S_T4: begin
                bus.Zin        = 1'b1;
                bus.ALU_opcode = opc;
                rout_en        = 1'b1;
                rout_idx       = (cls_q == CLS_BIN) ? rc : rb;
            end
            S_T5: begin
                bus.ZLOout = 1'b1;
                if (cls_q == CLS_MD) bus.LOin = 1'b1;
                else                 rin_en   = 1'b1;
            end
            S_T6: begin
                bus.ZHIout = 1'b1;
                bus.HIin   = 1'b1;
            end
            default: ;
        endcase
    end

    reg_sel_decoder u_rin_dec (
        .idx_i    (rin_idx),
        .en_i     (rin_en),
        .onehot_o (rin)
    );

    reg_sel_decoder u_rout_dec (
        .idx_i    (rout_idx),
        .en_i     (rout_en),
        .onehot_o (rout)
    );

    assign bus.Rin         = rin;
    assign bus.Rout        = rout;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.mem_timeout = timeout_q;

endmodule
